// File: rtl/arb_cfg_pkg.sv
// Shared configuration for the packet arbiter: arbitration modes, default sizes
// and a width helper.
package arb_cfg_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Bit width needed to index n items, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pkg.sv
// Single import point for arbiter consumers; re-exports the configuration package.
package arb_pkg;

  import arb_cfg_pkg::*;
  export arb_cfg_pkg::*;

  // Referencing every item makes sure the wildcard export carries all of them.
  localparam arb_mode_e DEF_ARB_MODE  = ARB_RR;
  localparam arb_mode_e ALT_ARB_MODE  = ARB_FIXED;
  localparam int        DEF_CH_W      = clog2_min1(DEF_NUM_CH);
  localparam int        DEF_FIFO_BITS = DEF_DATA_W * DEF_DEPTH;

endpackage

// File: rtl/arb_chan_fifo.sv
// Per-channel circular-buffer FIFO with a combinational head word.
module arb_chan_fifo
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arb_chan_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr_reg];
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// N-channel arbiter: per-channel FIFOs feeding one registered valid/ready output
// tagged with its source channel; round-robin or fixed-priority selection.
module pkt_rr_arbiter
  import arb_pkg::*;
#(
  parameter int        NUM_CH   = DEF_NUM_CH,
  parameter int        DATA_W   = DEF_DATA_W,
  parameter int        DEPTH    = DEF_DEPTH,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int       CH_W     = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        ch_empty
);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("pkt_rr_arbiter: NUM_CH must be >= 2");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pkt_rr_arbiter: DATA_W must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pkt_rr_arbiter: DEPTH must be a power of two and >= 2");
  end

  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_pop;
  logic [DATA_W-1:0] heads [NUM_CH];

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [CH_W-1:0]   out_ch_reg;
  logic [CH_W-1:0]   rr_ptr_reg;

  logic              load_en;
  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   rr_next;
  int                idx;

  assign load_en = ~out_valid_reg | out_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    arb_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid[gi]),
      .push_data (in_data[gi*DATA_W +: DATA_W]),
      .pop       (fifo_pop[gi]),
      .full      (fifo_full[gi]),
      .empty     (fifo_empty[gi]),
      .head      (heads[gi])
    );
    assign fifo_pop[gi] = load_en & gnt_valid & (gnt_ch == CH_W'(gi));
  end

  assign in_ready = ~fifo_full;
  assign ch_empty = fifo_empty;

  // Scan from the far end back towards the start so the last hit is the winner.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ARB_MODE == ARB_RR) begin
        idx = (int'(rr_ptr_reg) + k) % NUM_CH;
      end else begin
        idx = k;
      end
      if (!fifo_empty[idx]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
  end

  assign rr_next = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else if (load_en) begin
      out_valid_reg <= gnt_valid;
      if (gnt_valid) begin
        out_data_reg <= heads[gnt_ch];
        out_ch_reg   <= gnt_ch;
        if (ARB_MODE == ARB_RR) begin
          rr_ptr_reg <= rr_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus;
// a queue-level model predicts handshakes and per-cycle status for each.
module tb_pkt_rr_arbiter;
  import arb_pkg::*;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [31:0]   in_data;
  logic          out_ready;
  logic [3:0]    dut_in_ready [2];
  logic          dut_out_valid [2];
  logic [7:0]    dut_out_data [2];
  logic [1:0]    dut_out_ch [2];
  logic [3:0]    dut_ch_empty [2];

  pkt_rr_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(dut_in_ready[0]), .out_valid(dut_out_valid[0]), .out_data(dut_out_data[0]),
    .out_ch(dut_out_ch[0]), .out_ready(out_ready), .ch_empty(dut_ch_empty[0])
  );

  pkt_rr_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(dut_in_ready[1]), .out_valid(dut_out_valid[1]), .out_data(dut_out_data[1]),
    .out_ch(dut_out_ch[1]), .out_ready(out_ready), .ch_empty(dut_ch_empty[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel per instance, plus the output word.
  logic [7:0]  mq [8][$];
  logic        m_ov [2];
  logic [1:0]  m_och [2];
  logic [7:0]  m_od [2];
  int          m_ptr [2];
  logic [3:0]  last_acc [2];
  logic [9:0]  exp_q [2][$];
  logic [18:0] st_q [2][$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) mq[m*NCH + c].delete();
      m_ov[m]     = 1'b0;
      m_och[m]    = 2'd0;
      m_od[m]     = 8'd0;
      m_ptr[m]    = 0;
      last_acc[m] = 4'd0;
      exp_q[m].delete();
      st_q[m].delete();
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [3:0] rdy;
      logic [3:0] emp;
      int g;
      for (int c = 0; c < NCH; c++) begin
        rdy[c] = (mq[m*NCH + c].size() < DEPTH);
        emp[c] = (mq[m*NCH + c].size() == 0);
      end
      st_q[m].push_back({m_ov[m], m_och[m], m_od[m], rdy, emp});
      last_acc[m] = in_valid & rdy;
      if (m_ov[m] && out_ready) exp_q[m].push_back({m_och[m], m_od[m]});
      if (!m_ov[m] || out_ready) begin
        g = -1;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m == 0) ? (m_ptr[m] + k) % NCH : k;
          if (g < 0 && !emp[c]) g = c;
        end
        if (g >= 0) begin
          m_od[m]  = mq[m*NCH + g].pop_front();
          m_och[m] = 2'(g);
          m_ov[m]  = 1'b1;
          m_ptr[m] = (g + 1) % NCH;
        end else begin
          m_ov[m] = 1'b0;
        end
      end
      for (int c = 0; c < NCH; c++)
        if (last_acc[m][c]) mq[m*NCH + c].push_back(in_data[c*DW +: DW]);
    end
  endtask

  task automatic cycle(input logic [3:0] iv, input logic [31:0] id, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    model_step();
  endtask

  // Monitor: status every cycle, plus each handshake against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        if (st_q[m].size() > 0) begin
          logic [18:0] st;
          st = st_q[m].pop_front();
          chk(m == 0 ? "rr_status" : "fx_status",
              32'({dut_out_valid[m], dut_out_ch[m], dut_out_data[m], dut_in_ready[m], dut_ch_empty[m]}),
              32'(st));
        end
        if (dut_out_valid[m] && out_ready) begin
          if (exp_q[m].size() == 0) begin
            chk(m == 0 ? "rr_unexpected_out" : "fx_unexpected_out",
                32'({dut_out_ch[m], dut_out_data[m]}), 32'h3ff_0000);
          end else begin
            logic [9:0] e;
            e = exp_q[m].pop_front();
            chk(m == 0 ? "rr_out_word" : "fx_out_word",
                32'({dut_out_ch[m], dut_out_data[m]}), 32'(e));
          end
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_out_valid"}, 32'(dut_out_valid[m]), 32'd0);
      chk({tag, "_ch_empty"},  32'(dut_ch_empty[m]),  32'hf);
      chk({tag, "_in_ready"},  32'(dut_in_ready[m]),  32'hf);
    end
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 4'd0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset");
    chk("reset_out_ch",   32'(dut_out_ch[0]),   32'd0);
    chk("reset_out_data", 32'(dut_out_data[0]), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single word on ch2.
    cycle(4'b0100, 32'h00A5_0000, 1'b1);
    repeat (3) cycle(4'b0000, 32'd0, 1'b1);

    // RR fairness: two words per channel, then release.
    cycle(4'b1111, 32'h1312_1110, 1'b0);
    cycle(4'b1111, 32'h2322_2120, 1'b0);
    repeat (3) cycle(4'b0000, 32'd0, 1'b0);
    repeat (10) cycle(4'b0000, 32'd0, 1'b1);

    // Async reset while a word is held in the output register.
    cycle(4'b0011, 32'h0000_5150, 1'b0);
    cycle(4'b0011, 32'h0000_6160, 1'b0);
    cycle(4'b0000, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) cycle(4'b0000, 32'd0, 1'b1);

    // Backpressure: words 1..6 offered on ch0 with the output stalled.
    w = 1;
    for (int t = 0; t < 10; t++) begin
      cycle({3'b000, w <= 6}, 32'(w), 1'b0);
      if (last_acc[0][0]) w++;
    end
    repeat (10) cycle(4'b0000, 32'd0, 1'b1);

    // Fixed-priority contention between ch1 and ch3.
    cycle(4'b1010, 32'h3100_1100, 1'b0);
    cycle(4'b1010, 32'h3200_1200, 1'b0);
    cycle(4'b1010, 32'h3300_1300, 1'b0);
    repeat (10) cycle(4'b0000, 32'd0, 1'b1);

    // Pointer wrap: 3*DEPTH words on ch0 with out_ready toggling.
    w = 0;
    for (int t = 0; t < 80 && w < 3*DEPTH; t++) begin
      cycle(4'b0001, 32'h40 + 32'(w), (t % 2) == 0);
      if (last_acc[0][0]) w++;
    end
    repeat (3*DEPTH + 4) cycle(4'b0000, 32'd0, 1'b1);

    // Random traffic.
    for (int t = 0; t < 600; t++)
      cycle(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));

    repeat (40) cycle(4'b0000, 32'd0, 1'b1);
    @(negedge clk);
    #1;
    chk("rr_exp_drained", 32'(exp_q[0].size()), 32'd0);
    chk("fx_exp_drained", 32'(exp_q[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Parametrised N-channel round-robin arbiter. Each channel has its own input FIFO. The output is a registered valid/ready stream tagged with the source channel.
- Serves as the multi-channel RTL consumer of the shared-configuration package chain. Configuration constants and types reach the block through a single re-exporting package, so no conflicting wildcard imports occur.
- Generalises the single-constant package pattern to width, depth, channel count and arbitration mode.

Parameters:
- NUM_CH, 4, number of input channels; must be >= 2.
- DATA_W, 8, payload width in bits; must be >= 1.
- DEPTH, 4, per-channel FIFO depth; must be a power of two and >= 2.
- ARB_MODE, ARB_RR, arbitration mode of type arb_mode_e: ARB_RR is round-robin, ARB_FIXED is lowest index wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_CH  per-channel write strobe.
- in_data  in  NUM_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel FIFO not full.
- out_valid  out  1  output word present.
- out_data  out  DATA_W  output payload.
- out_ch  out  CH_W  source channel of out_data; CH_W = max(1, clog2(NUM_CH)).
- out_ready  in  1  downstream accept.
- ch_empty  out  NUM_CH  per-channel FIFO empty flag.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; in_ready all ones; ch_empty all ones; out_valid=0; out_data=0; out_ch=0; RR pointer=0. Reset asserted mid-stream discards all buffered and output data immediately, without a clock edge.
- Input push: channel i accepts a word on an edge where in_valid[i] & in_ready[i].
- in_ready[i] = !full[i], decoded from registered count only, with no combinational path from out_ready.
- A full FIFO refuses a push even in the cycle it pops. in_valid while in_ready=0 is ignored, with no error and no state change.
- FIFO structure: circular buffer with read/write pointers wrapping modulo DEPTH and count width clog2(DEPTH+1). Push and pop in the same cycle leave count unchanged.
- Output register load condition: load_en = !out_valid | out_ready.
  - When load_en and at least one FIFO is non-empty: grant one channel g, pop its head into out_data, set out_ch=g, set out_valid=1.
  - When load_en and all FIFOs are empty: out_valid goes to 0 and out_data/out_ch hold their last values.
- Hold: while out_valid & !out_ready, out_data and out_ch are stable and no FIFO pops.
- Latency: a word accepted into an empty FIFO on edge k, with an idle output, appears with out_valid=1 after edge k+1. Sustained throughput is 1 word per cycle.
- ARB_RR: search starts at the pointer and wraps upward modulo NUM_CH. After a grant to g, pointer=(g+1) mod NUM_CH. With no grant, the pointer is unchanged.
- ARB_FIXED: lowest-index non-empty channel wins; the pointer is unused.
- Ordering: per-channel FIFO order is preserved; no reordering within a channel.
- ch_empty[i] reflects the registered count. A word sitting in the output register is not counted.
- Illegal parameters (NUM_CH<2, DEPTH not a power of two or <2, DATA_W<1) produce an elaboration-time $error.

Decomposition:
- Package arb_cfg_pkg holds:
  - typedef enum arb_mode_e {ARB_RR, ARB_FIXED};
  - default constants DEF_NUM_CH, DEF_DATA_W, DEF_DEPTH;
  - function clog2_min1.
- Package arb_pkg imports arb_cfg_pkg::* and re-exports it with export arb_cfg_pkg::*. The module imports only arb_pkg::*.
- Sub-module arb_chan_fifo (DATA_W, DEPTH): push/pop/full/empty/head, instantiated NUM_CH times by a generate loop.
- Arbitration and the output register live in the top module.

Test Plan:
- Reset: hold rst_n=0 -> out_valid=0, out_ch=0, in_ready=4'b1111, ch_empty=4'b1111. Pulse rst_n low asynchronously while out_valid=1 -> out_valid=0 before the next clk edge, and all FIFOs are empty afterwards.
- Single word: push 8'hA5 on ch2 at edge k with out_ready=1 -> after edge k+1, out_valid=1, out_data=8'hA5, out_ch=2; the following cycle out_valid=0.
- RR fairness: preload 2 words per channel with out_ready=0, then set out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3, then out_valid=0.
- Backpressure/full: out_ready=0, drive ch0 with words 1..6 continuously.
  - Exactly 5 words are accepted (1 in the output register, 4 in the FIFO); in_ready[0]=0 and out_data=1 stay stable.
  - Then set out_ready=1 -> output 1,2,3,4,5 in order, and in_ready[0] returns to 1.
- Fixed mode: ARB_MODE=ARB_FIXED, keep ch1 and ch3 both non-empty -> every grant goes to ch1 until it is empty; ch3 words follow.
- Wrap-around: on ch0, stream 3*DEPTH words with out_ready toggling 1,0,1,0 -> all words arrive intact and in order, with no loss or duplication across pointer wraps.
